clk_period_meter: RTL and testbench

- Measurement end of the clock-divider path: observes a divided or slow clock (e.g. the output of the team's clock divider) in the system clk domain.
- Reports the clk-cycle period and high time of the observed clock, a per-period valid strobe, a lock indicator and a loss-of-clock timeout.
- Used to check divider ratios at runtime and to gate game logic until the pixel/game-tick clocks are stable.

---
 rtl/clk_period_meter.sv | 103 ++++++++++
 tb/tb_clk_period_meter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// Measures the period and high time of a slow clock (sig_in) in clk cycles,
// with a per-measurement strobe, an exact-match lock flag and a loss-of-clock timeout.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | waiting for a first rising edge to arm (after reset/timeout)
//  MEAS  | counting the current period; each rise closes a measurement
module clk_period_meter #(
    parameter int NBIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sig_in,
    output logic [NBIT-1:0] period,
    output logic [NBIT-1:0] high_time,
    output logic            meas_valid,
    output logic            locked,
    output logic            timeout
);

    localparam logic [NBIT-1:0] MAXCNT = '1;
    localparam logic [NBIT-1:0] ONE    = {{(NBIT-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    state_t          state;
    logic            s1;
    logic            s2;
    logic            s2_d;
    logic            rise;
    logic [NBIT-1:0] cnt;
    logic [NBIT-1:0] hcnt;
    logic [NBIT-1:0] prev_cnt;
    logic [NBIT-1:0] prev_hcnt;

    assign rise = s2 & ~s2_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s2_d       <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            hcnt       <= '0;
            prev_cnt   <= '0;
            prev_hcnt  <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            s1         <= sig_in;
            s2         <= s1;
            s2_d       <= s2;
            meas_valid <= 1'b0;

            case (state)
                IDLE: begin
                    // First edge only arms the counters; nothing is reported.
                    if (rise) begin
                        cnt     <= ONE;
                        hcnt    <= ONE;
                        timeout <= 1'b0;
                        state   <= MEAS;
                    end
                end

                MEAS: begin
                    // A rise on the terminal count still closes a valid period.
                    if (rise) begin
                        period     <= cnt;
                        high_time  <= hcnt;
                        meas_valid <= 1'b1;
                        locked     <= (cnt == prev_cnt) && (hcnt == prev_hcnt);
                        prev_cnt   <= cnt;
                        prev_hcnt  <= hcnt;
                        cnt        <= ONE;
                        hcnt       <= ONE;
                    end else if (cnt == MAXCNT) begin
                        timeout   <= 1'b1;
                        locked    <= 1'b0;
                        prev_cnt  <= '0;
                        prev_hcnt <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + ONE;
                        if (s2 && (hcnt != MAXCNT)) begin
                            hcnt <= hcnt + ONE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: per-scenario tasks drive sig_in waveforms
// and compare recorded measurements against hand-computed values.
module tb_clk_period_meter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sig_in = 1'b0;
    logic [7:0] period;
    logic [7:0] high_time;
    logic       meas_valid;
    logic       locked;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic to_seen = 1'b0;

    typedef struct {
        int         c;
        logic [7:0] p;
        logic [7:0] h;
        logic       l;
    } meas_t;
    meas_t q[$];

    clk_period_meter #(.NBIT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every measurement strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (meas_valid) q.push_back('{cyc, period, high_time, locked});
        if (timeout) to_seen = 1'b1;
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        sig_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        to_seen = 1'b0;
    endtask

    // n periods of length p with sig_in high for the first h cycles of each.
    task automatic drive_wave(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < p; j++) begin
                @(posedge clk); #1;
                sig_in = (j < h);
            end
        end
    endtask

    task automatic check_series(input string name, input int n_exp, input logic [7:0] p_exp,
                                input logic [7:0] h_exp, input int spacing);
        n_checks++;
        if (q.size() != n_exp) begin
            n_errors++;
            $display("FAIL %s count: got %0d want %0d", name, q.size(), n_exp);
        end
        for (int i = 0; i < q.size() && i < n_exp; i++) begin
            n_checks++;
            if ({q[i].p, q[i].h, q[i].l} !== {p_exp, h_exp, (i != 0)}) begin
                n_errors++;
                $display("FAIL %s meas[%0d]: got p=%0d h=%0d l=%0b want p=%0d h=%0d l=%0b",
                         name, i, q[i].p, q[i].h, q[i].l, p_exp, h_exp, (i != 0));
            end
            if (i > 0) begin
                n_checks++;
                if (q[i].c - q[i-1].c != spacing) begin
                    n_errors++;
                    $display("FAIL %s spacing[%0d]: got %0d want %0d",
                             name, i, q[i].c - q[i-1].c, spacing);
                end
            end
        end
    endtask

    task automatic check_zero_outputs(input string name);
        n_checks++;
        if ({period, high_time, meas_valid, locked, timeout} !== 19'd0) begin
            n_errors++;
            $display("FAIL %s outputs: got p=%0d h=%0d v=%0b l=%0b t=%0b want all 0",
                     name, period, high_time, meas_valid, locked, timeout);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        check_zero_outputs("reset");
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset_idle");
    endtask

    task automatic test_div4();
        do_reset();
        drive_wave(4, 2, 5);
        repeat (4) @(posedge clk);
        check_series("div4", 4, 8'd4, 8'd2, 4);
    endtask

    task automatic test_div3();
        do_reset();
        drive_wave(3, 1, 6);
        repeat (4) @(posedge clk);
        check_series("div3", 5, 8'd3, 8'd1, 3);
    endtask

    task automatic test_timeout();
        int c0;
        int ct;
        bit hit;
        do_reset();
        drive_wave(10, 5, 4);
        @(negedge clk);
        check_series("to_lock", 3, 8'd10, 8'd5, 10);
        c0 = (q.size() > 0) ? q[$].c : 0;
        hit = 1'b0;
        ct = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            if (timeout) begin
                hit = 1'b1;
                ct = cyc;
            end
        end
        n_checks++;
        if (!hit || (ct - c0) != 255) begin
            n_errors++;
            $display("FAIL timeout_delay: got hit=%0b delay=%0d want delay=255", hit, ct - c0);
        end
        n_checks++;
        if ({locked, period, high_time} !== {1'b0, 8'd10, 8'd5}) begin
            n_errors++;
            $display("FAIL timeout_state: got l=%0b p=%0d h=%0d want l=0 p=10 h=5",
                     locked, period, high_time);
        end
        q.delete();
        drive_wave(10, 5, 1);
        @(negedge clk);
        n_checks++;
        if (timeout !== 1'b0 || q.size() != 0) begin
            n_errors++;
            $display("FAIL timeout_clear: got t=%0b meas=%0d want t=0 meas=0", timeout, q.size());
        end
        drive_wave(10, 5, 2);
        repeat (4) @(posedge clk);
        check_series("relock", 2, 8'd10, 8'd5, 10);
    endtask

    task automatic test_ratio_change();
        logic [7:0] pe [6] = '{8'd8, 8'd8, 8'd8, 8'd8, 8'd6, 8'd6};
        logic [7:0] he [6] = '{8'd4, 8'd4, 8'd4, 8'd4, 8'd3, 8'd3};
        logic       le [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        drive_wave(8, 4, 4);
        drive_wave(6, 3, 3);
        repeat (4) @(posedge clk);
        n_checks++;
        if (q.size() != 6) begin
            n_errors++;
            $display("FAIL ratio count: got %0d want 6", q.size());
        end
        for (int i = 0; i < q.size() && i < 6; i++) begin
            n_checks++;
            if ({q[i].p, q[i].h, q[i].l} !== {pe[i], he[i], le[i]}) begin
                n_errors++;
                $display("FAIL ratio meas[%0d]: got p=%0d h=%0d l=%0b want p=%0d h=%0d l=%0b",
                         i, q[i].p, q[i].h, q[i].l, pe[i], he[i], le[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive_wave(6, 3, 4);
        @(negedge clk);
        n_checks++;
        if (locked !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_prelock: got l=%0b want 1", locked);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero_outputs("midrst");
        q.delete();
        drive_wave(6, 3, 3);
        repeat (4) @(posedge clk);
        check_series("midrst_after", 2, 8'd6, 8'd3, 6);
    endtask

    task automatic test_boundary();
        do_reset();
        drive_wave(2, 1, 5);
        repeat (4) @(posedge clk);
        check_series("toggle", 4, 8'd2, 8'd1, 2);
        do_reset();
        drive_wave(255, 1, 3);
        repeat (4) @(posedge clk);
        check_series("p255", 2, 8'd255, 8'd1, 255);
        n_checks++;
        if (to_seen !== 1'b0) begin
            n_errors++;
            $display("FAIL p255_timeout: got timeout seen=%0b want 0", to_seen);
        end
    endtask

    initial begin
        test_reset();
        test_div4();
        test_div3();
        test_timeout();
        test_ratio_change();
        test_mid_reset();
        test_boundary();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
